// File: rtl/rasterizer_backend.sv
// Triangle traversal back end: walks the bounding box row-major, one pixel per cycle,
// and emits (x, y, z) fragments for pixels inside all three edges, with output backpressure.
module rasterizer_backend #(
  parameter int DATAWIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rstn,
  output logic                          ready,
  input  logic                          i_dv,
  input  logic signed [DATAWIDTH-1:0]   bb_tl [2],
  input  logic signed [DATAWIDTH-1:0]   bb_br [2],
  input  logic signed [2*DATAWIDTH-1:0] edge_val0,
  input  logic signed [2*DATAWIDTH-1:0] edge_val1,
  input  logic signed [2*DATAWIDTH-1:0] edge_val2,
  input  logic signed [DATAWIDTH-1:0]   edge_delta0 [2],
  input  logic signed [DATAWIDTH-1:0]   edge_delta1 [2],
  input  logic signed [DATAWIDTH-1:0]   edge_delta2 [2],
  input  logic signed [DATAWIDTH-1:0]   z_coeff,
  input  logic signed [DATAWIDTH-1:0]   z_coeff_delta [2],
  output logic signed [DATAWIDTH-1:0]   o_frag_x,
  output logic signed [DATAWIDTH-1:0]   o_frag_y,
  output logic        [DATAWIDTH-1:0]   o_frag_z,
  output logic                          o_frag_dv,
  input  logic                          i_frag_ready,
  output logic                          o_tri_done
);

  localparam int EW = 2 * DATAWIDTH;

  typedef enum logic [1:0] {IDLE, TRAVERSE, DONE} state_t;

  state_t                      state;
  logic signed [DATAWIDTH-1:0] tl_x, br_x, br_y, x, y;
  logic signed [DATAWIDTH-1:0] dx [3];
  logic signed [DATAWIDTH-1:0] dy [3];
  logic signed [DATAWIDTH-1:0] zdx, zdy;
  logic signed [EW-1:0]        e [3];
  logic signed [EW-1:0]        e_row [3];
  logic signed [EW-1:0]        z, z_row;
  logic                        inside_p0, stall;

  function automatic logic signed [EW-1:0] sext(input logic signed [DATAWIDTH-1:0] v);
    return {{DATAWIDTH{v[DATAWIDTH-1]}}, v};
  endfunction

  // Depth leaves the block as the raw low bits: wraps, never clamps.
  function automatic logic [DATAWIDTH-1:0] trunc_z(input logic signed [EW-1:0] v);
    return v[DATAWIDTH-1:0];
  endfunction

  always_comb begin
    inside_p0 = ~e[0][EW-1] & ~e[1][EW-1] & ~e[2][EW-1];
    stall     = o_frag_dv & ~i_frag_ready;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      ready      <= 1'b1;
      o_tri_done <= 1'b0;
      o_frag_dv  <= 1'b0;
      o_frag_x   <= '0;
      o_frag_y   <= '0;
      o_frag_z   <= '0;
      tl_x       <= '0;
      br_x       <= '0;
      br_y       <= '0;
      x          <= '0;
      y          <= '0;
      zdx        <= '0;
      zdy        <= '0;
      z          <= '0;
      z_row      <= '0;
      for (int i = 0; i < 3; i++) begin
        dx[i]    <= '0;
        dy[i]    <= '0;
        e[i]     <= '0;
        e_row[i] <= '0;
      end
    end else begin
      case (state)
        // p0: capture the set-up triangle
        IDLE: begin
          if (i_dv) begin
            ready    <= 1'b0;
            tl_x     <= bb_tl[0];
            br_x     <= bb_br[0];
            br_y     <= bb_br[1];
            x        <= bb_tl[0];
            y        <= bb_tl[1];
            dx[0]    <= edge_delta0[0];
            dy[0]    <= edge_delta0[1];
            dx[1]    <= edge_delta1[0];
            dy[1]    <= edge_delta1[1];
            dx[2]    <= edge_delta2[0];
            dy[2]    <= edge_delta2[1];
            zdx      <= z_coeff_delta[0];
            zdy      <= z_coeff_delta[1];
            e[0]     <= edge_val0;
            e[1]     <= edge_val1;
            e[2]     <= edge_val2;
            e_row[0] <= edge_val0;
            e_row[1] <= edge_val1;
            e_row[2] <= edge_val2;
            z        <= sext(z_coeff);
            z_row    <= sext(z_coeff);
            if (bb_br[0] < bb_tl[0] || bb_br[1] < bb_tl[1]) begin
              state      <= DONE;
              o_tri_done <= 1'b1;
            end else begin
              state <= TRAVERSE;
            end
          end
        end
        // p1: evaluate current pixel into the fragment register, then step
        TRAVERSE: begin
          if (!stall) begin
            o_frag_dv <= inside_p0;
            if (inside_p0) begin
              o_frag_x <= x;
              o_frag_y <= y;
              o_frag_z <= trunc_z(z);
            end
            if (x < br_x) begin
              x <= x + DATAWIDTH'(1);
              for (int i = 0; i < 3; i++) e[i] <= e[i] + sext(dx[i]);
              z <= z + sext(zdx);
            end else if (y < br_y) begin
              x <= tl_x;
              y <= y + DATAWIDTH'(1);
              for (int i = 0; i < 3; i++) begin
                e_row[i] <= e_row[i] + sext(dy[i]);
                e[i]     <= e_row[i] + sext(dy[i]);
              end
              z_row <= z_row + sext(zdy);
              z     <= z_row + sext(zdy);
            end else begin
              state      <= DONE;
              // A last inside pixel is still pending; DONE waits for its acceptance.
              o_tri_done <= ~inside_p0;
            end
          end
        end
        // p2: drain the final fragment, pulse done, return to idle
        DONE: begin
          if (o_tri_done) begin
            o_tri_done <= 1'b0;
            ready      <= 1'b1;
            state      <= IDLE;
          end else if (!o_frag_dv || i_frag_ready) begin
            o_frag_dv  <= 1'b0;
            o_tri_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rasterizer_backend.sv
// Directed bench for rasterizer_backend: table of triangles with hand-computed fragments,
// plus backpressure and mid-traversal reset sequences.
module tb_rasterizer_backend;

  localparam int DW = 12;
  localparam int NV = 4;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   ready;
  logic                   i_dv;
  logic signed [DW-1:0]   bb_tl [2];
  logic signed [DW-1:0]   bb_br [2];
  logic signed [2*DW-1:0] edge_val0, edge_val1, edge_val2;
  logic signed [DW-1:0]   edge_delta0 [2];
  logic signed [DW-1:0]   edge_delta1 [2];
  logic signed [DW-1:0]   edge_delta2 [2];
  logic signed [DW-1:0]   z_coeff;
  logic signed [DW-1:0]   z_coeff_delta [2];
  logic signed [DW-1:0]   o_frag_x, o_frag_y;
  logic        [DW-1:0]   o_frag_z;
  logic                   o_frag_dv;
  logic                   i_frag_ready;
  logic                   o_tri_done;

  rasterizer_backend #(.DATAWIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .ready(ready), .i_dv(i_dv),
    .bb_tl(bb_tl), .bb_br(bb_br),
    .edge_val0(edge_val0), .edge_val1(edge_val1), .edge_val2(edge_val2),
    .edge_delta0(edge_delta0), .edge_delta1(edge_delta1), .edge_delta2(edge_delta2),
    .z_coeff(z_coeff), .z_coeff_delta(z_coeff_delta),
    .o_frag_x(o_frag_x), .o_frag_y(o_frag_y), .o_frag_z(o_frag_z),
    .o_frag_dv(o_frag_dv), .i_frag_ready(i_frag_ready), .o_tri_done(o_tri_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tlx, tly, brx, bry;
    int e0, e1, e2;
    int d0x, d0y, d1x, d1y, d2x, d2y;
    int z, zdx, zdy;
    int nfrag;
    int done_cyc;
  } vec_t;

  vec_t vecs [NV];
  int   exp_fx [NV][6];
  int   exp_fy [NV][6];
  int   exp_fz [NV][6];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic load(input int idx);
    vec_t v;
    v = vecs[idx];
    bb_tl[0] = DW'(v.tlx);  bb_tl[1] = DW'(v.tly);
    bb_br[0] = DW'(v.brx);  bb_br[1] = DW'(v.bry);
    edge_val0 = (2*DW)'(v.e0);
    edge_val1 = (2*DW)'(v.e1);
    edge_val2 = (2*DW)'(v.e2);
    edge_delta0[0] = DW'(v.d0x);  edge_delta0[1] = DW'(v.d0y);
    edge_delta1[0] = DW'(v.d1x);  edge_delta1[1] = DW'(v.d1y);
    edge_delta2[0] = DW'(v.d2x);  edge_delta2[1] = DW'(v.d2y);
    z_coeff = DW'(v.z);
    z_coeff_delta[0] = DW'(v.zdx);  z_coeff_delta[1] = DW'(v.zdy);
  endtask

  // Cycle k is sampled at the negedge between capture edge + (k-1) and capture edge + k.
  task automatic run_vec(input int idx, input int stall, input int exp_done);
    int  nrec = 0;
    int  stall_left = 0;
    bit  seen_first = 0;
    bit  done_seen = 0;
    load(idx);
    i_frag_ready = 1'b1;
    i_dv = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      i_dv = 1'b0;
      if (o_frag_dv && !seen_first) begin
        seen_first = 1;
        stall_left = stall;
      end
      if (stall_left > 0) begin
        i_frag_ready = 1'b0;
        chk($sformatf("v%0d hold_dv", idx), 32'(o_frag_dv), 1);
        chk($sformatf("v%0d hold_x", idx), 32'(o_frag_x), 32'(exp_fx[idx][0]));
        chk($sformatf("v%0d hold_y", idx), 32'(o_frag_y), 32'(exp_fy[idx][0]));
        chk($sformatf("v%0d hold_z", idx), 32'(o_frag_z), 32'(exp_fz[idx][0]));
        stall_left--;
      end else begin
        i_frag_ready = 1'b1;
      end
      if (o_frag_dv && i_frag_ready) begin
        if (nrec < 6) begin
          chk($sformatf("v%0d frag%0d_x", idx, nrec), 32'(o_frag_x), 32'(exp_fx[idx][nrec]));
          chk($sformatf("v%0d frag%0d_y", idx, nrec), 32'(o_frag_y), 32'(exp_fy[idx][nrec]));
          chk($sformatf("v%0d frag%0d_z", idx, nrec), 32'(o_frag_z), 32'(exp_fz[idx][nrec]));
        end
        nrec++;
      end
      if (o_tri_done) begin
        done_seen = 1;
        chk($sformatf("v%0d done_cycle", idx), 32'(cyc), 32'(exp_done));
        chk($sformatf("v%0d ready_in_done", idx), 32'(ready), 0);
        break;
      end
    end
    chk($sformatf("v%0d done_seen", idx), 32'(done_seen), 1);
    chk($sformatf("v%0d frag_count", idx), 32'(nrec), 32'(vecs[idx].nfrag));
    @(negedge clk);
    chk($sformatf("v%0d ready_after", idx), 32'(ready), 1);
    chk($sformatf("v%0d done_one_cycle", idx), 32'(o_tri_done), 0);
  endtask

  initial begin
    vecs[0] = '{tlx:0, tly:0, brx:1, bry:1, e0:0, e1:0, e2:1,
                d0x:1, d0y:0, d1x:0, d1y:1, d2x:-1, d2y:-1,
                z:100, zdx:10, zdy:20, nfrag:3, done_cyc:5};
    exp_fx[0] = '{0, 1, 0, 0, 0, 0};
    exp_fy[0] = '{0, 0, 1, 0, 0, 0};
    exp_fz[0] = '{100, 110, 120, 0, 0, 0};
    vecs[1] = '{tlx:5, tly:5, brx:4, bry:5, e0:0, e1:0, e2:0,
                d0x:0, d0y:0, d1x:0, d1y:0, d2x:0, d2y:0,
                z:0, zdx:0, zdy:0, nfrag:0, done_cyc:1};
    exp_fx[1] = '{0, 0, 0, 0, 0, 0};
    exp_fy[1] = '{0, 0, 0, 0, 0, 0};
    exp_fz[1] = '{0, 0, 0, 0, 0, 0};
    vecs[2] = '{tlx:0, tly:0, brx:3, bry:2, e0:-1, e1:0, e2:0,
                d0x:0, d0y:0, d1x:0, d1y:0, d2x:0, d2y:0,
                z:7, zdx:1, zdy:1, nfrag:0, done_cyc:13};
    exp_fx[2] = '{0, 0, 0, 0, 0, 0};
    exp_fy[2] = '{0, 0, 0, 0, 0, 0};
    exp_fz[2] = '{0, 0, 0, 0, 0, 0};
    vecs[3] = '{tlx:2, tly:3, brx:4, bry:4, e0:5, e1:5, e2:5,
                d0x:-1, d0y:-2, d1x:-1, d1y:-2, d2x:-1, d2y:-2,
                z:0, zdx:1, zdy:-4, nfrag:6, done_cyc:8};
    exp_fx[3] = '{2, 3, 4, 2, 3, 4};
    exp_fy[3] = '{3, 3, 3, 4, 4, 4};
    exp_fz[3] = '{0, 1, 2, 'hFFC, 'hFFD, 'hFFE};

    rstn = 1'b0;
    i_dv = 1'b0;
    i_frag_ready = 1'b1;
    load(1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset ready", 32'(ready), 1);
    chk("reset dv", 32'(o_frag_dv), 0);
    chk("reset done", 32'(o_tri_done), 0);
    chk("reset x", 32'(o_frag_x), 0);
    chk("reset z", 32'(o_frag_z), 0);

    for (int i = 0; i < NV; i++) run_vec(i, 0, vecs[i].done_cyc);

    // First fragment held for five cycles; everything after shifts by five.
    run_vec(0, 5, 10);

    // Reset during the second traverse cycle abandons the triangle.
    load(0);
    i_dv = 1'b1;
    @(negedge clk);
    i_dv = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst ready", 32'(ready), 1);
    chk("midrst dv", 32'(o_frag_dv), 0);
    chk("midrst done", 32'(o_tri_done), 0);
    chk("midrst x", 32'(o_frag_x), 0);
    chk("midrst y", 32'(o_frag_y), 0);
    chk("midrst z", 32'(o_frag_z), 0);
    begin
      bit any_done = 0;
      bit any_dv = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (o_tri_done) any_done = 1;
        if (o_frag_dv) any_dv = 1;
      end
      chk("midrst no_done_after", 32'(any_done), 0);
      chk("midrst no_frag_after", 32'(any_dv), 0);
    end
    run_vec(3, 0, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
